// File: rtl/syn_sram_acc_arb_pkg.sv
// Shared types and the round-robin pick helper for the SRAM access arbiter.
package syn_sram_acc_arb_pkg;

  // Default requester count.
  localparam int NUM_AGENTS_DEF = 4;
  // Largest supported requester count. Tags and pointers are sized for it so any NUM_AGENTS in 2..8 fits.
  localparam int NUM_AGENTS_MAX = 8;
  localparam int AGT_IDX_W      = $clog2(NUM_AGENTS_MAX);

  typedef logic [AGT_IDX_W-1:0] agt_idx_t;

  typedef struct packed {
    logic     valid;
    agt_idx_t idx;
  } pick_t;

  // First requester at index >= ptr, wrapping. Request bits at and above NUM_AGENTS
  // are zero, so scanning modulo NUM_AGENTS_MAX gives the same order as scanning
  // modulo the real agent count.
  function automatic pick_t rr_pick(input logic [NUM_AGENTS_MAX-1:0] req,
                                    input agt_idx_t                  ptr);
    pick_t    res;
    agt_idx_t cand;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < NUM_AGENTS_MAX; k++) begin
      cand = ptr + agt_idx_t'(k);
      if (!res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/syn_sram_acc_tag_fifo.sv
// In-order FIFO of requester tags, one entry per outstanding SRAM read.
// Push and pop in the same cycle are allowed even when the FIFO is full.
module syn_sram_acc_tag_fifo
  import syn_sram_acc_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_ir,
  input  logic             rst_il,
  input  logic             push,
  input  agt_idx_t         push_tag,
  input  logic             pop,
  output agt_idx_t         head_tag,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  agt_idx_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_s;
  logic             rd_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;

  // Qualify push/pop against the current fill level and compute wrapped pointers.
  always_comb begin
    rd_s = pop & ~empty;
    wr_s = push & (~full | rd_s);
    if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
      wr_ptr_nxt_s = '0;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end
    if (rd_ptr_r == PTR_W'(DEPTH - 1)) begin
      rd_ptr_nxt_s = '0;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_nxt_s;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_ir) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= push_tag;
    end
  end

  assign head_tag = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign full     = (count_r == CNT_W'(DEPTH));
  assign empty    = (count_r == '0);

endmodule

// File: rtl/syn_sram_acc_arb.sv
// Round-robin arbiter sharing one SRAM command bus between NUM_AGENTS requesters,
// with in-order routing of read data back to the agent that issued each read.
module syn_sram_acc_arb
  import syn_sram_acc_arb_pkg::*;
#(
  parameter int NUM_AGENTS = NUM_AGENTS_DEF,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int MAX_RD_OUT = 4
) (
  input  logic                             clk_ir,
  input  logic                             rst_il,
  input  logic [NUM_AGENTS-1:0]            agt_rd_en,
  input  logic [NUM_AGENTS-1:0]            agt_wr_en,
  input  logic [NUM_AGENTS-1:0][ADDR_W-1:0] agt_addr,
  input  logic [NUM_AGENTS-1:0][DATA_W-1:0] agt_wr_data,
  output logic [NUM_AGENTS-1:0]            agt_rdy,
  output logic [NUM_AGENTS-1:0]            agt_rd_valid,
  output logic [DATA_W-1:0]                agt_rd_data,
  input  logic                             sram_rdy,
  output logic                             sram_rd_en,
  output logic                             sram_wr_en,
  output logic [ADDR_W-1:0]                sram_addr,
  output logic [DATA_W-1:0]                sram_wr_data,
  input  logic                             sram_rd_valid,
  input  logic [DATA_W-1:0]                sram_rd_data,
  output logic                             orphan_err
);

  localparam int       IDX_W    = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam int       CNT_W    = $clog2(MAX_RD_OUT) + 1;
  localparam agt_idx_t LAST_AGT = agt_idx_t'(NUM_AGENTS - 1);

  logic [NUM_AGENTS_MAX-1:0] req_pad_s;
  pick_t                     pick_s;
  agt_idx_t                  grant_s;
  logic [IDX_W-1:0]          gidx_s;
  agt_idx_t                  rr_ptr_r;
  agt_idx_t                  rr_ptr_nxt_s;
  logic                      fire_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  agt_idx_t                  fifo_head_s;
  logic [NUM_AGENTS-1:0]     head_oh_s;
  // Occupancy is kept visible for debug; the arbiter only needs full/empty.
  logic [CNT_W-1:0]          fifo_count_unused;

  // Round-robin grant from rr_ptr over agents requesting a read or a write.
  always_comb begin
    req_pad_s                 = '0;
    req_pad_s[NUM_AGENTS-1:0] = agt_rd_en | agt_wr_en;
    pick_s                    = rr_pick(req_pad_s, rr_ptr_r);
    grant_s                   = pick_s.idx;
    gidx_s                    = grant_s[IDX_W-1:0];
  end

  // Forward the granted command; a read-and-write request is a write, and reads stall while the tag FIFO is full.
  always_comb begin
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_addr    = '0;
    sram_wr_data = '0;
    if (pick_s.valid) begin
      sram_wr_en   = agt_wr_en[gidx_s];
      sram_rd_en   = agt_rd_en[gidx_s] & ~agt_wr_en[gidx_s] & ~fifo_full_s;
      sram_addr    = agt_addr[gidx_s];
      sram_wr_data = agt_wr_data[gidx_s];
    end else begin
      sram_rd_en = 1'b0;
      sram_wr_en = 1'b0;
    end
  end

  // Handshake back to the granted agent and tag FIFO controls.
  always_comb begin
    agt_rdy = '0;
    fire_s  = sram_rdy & (sram_wr_en | sram_rd_en);
    push_s  = fire_s & sram_rd_en;
    pop_s   = sram_rd_valid & ~fifo_empty_s;
    if (fire_s) begin
      agt_rdy[gidx_s] = 1'b1;
    end else begin
      agt_rdy = '0;
    end
  end

  // Next round-robin start: one past the agent that just transferred.
  always_comb begin
    if (grant_s == LAST_AGT) begin
      rr_ptr_nxt_s = '0;
    end else begin
      rr_ptr_nxt_s = grant_s + agt_idx_t'(1);
    end
  end

  // Round-robin pointer advances only on a completed transfer.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      rr_ptr_r <= '0;
    end else if (fire_s) begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  syn_sram_acc_tag_fifo #(
    .DEPTH (MAX_RD_OUT),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_ir   (clk_ir),
    .rst_il   (rst_il),
    .push     (push_s),
    .push_tag (grant_s),
    .pop      (pop_s),
    .head_tag (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_unused)
  );

  // Decode the owner of the oldest outstanding read.
  always_comb begin
    head_oh_s = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      head_oh_s[i] = (fifo_head_s == agt_idx_t'(i));
    end
  end

  // Registered read return routing and sticky orphan-return flag.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      agt_rd_valid <= '0;
      agt_rd_data  <= '0;
      orphan_err   <= 1'b0;
    end else begin
      agt_rd_valid <= head_oh_s & {NUM_AGENTS{pop_s}};
      if (sram_rd_valid) begin
        agt_rd_data <= sram_rd_data;
      end
      if (sram_rd_valid & fifo_empty_s) begin
        orphan_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// Self-checking bench for syn_sram_acc_arb: directed command checks plus a
// scoreboard of expected read returns compared when the DUT routes them.
module tb_syn_sram_acc_arb;

  localparam int NA  = 4;
  localparam int DW  = 16;
  localparam int AW  = 18;
  localparam int MRO = 4;

  logic                  clk_ir = 1'b0;
  logic                  rst_il;
  logic [NA-1:0]         rd_en_b;
  logic [NA-1:0]         wr_en_b;
  logic [NA-1:0][AW-1:0] addr_b;
  logic [NA-1:0][DW-1:0] wdata_b;
  logic [NA-1:0]         agt_rdy;
  logic [NA-1:0]         agt_rd_valid;
  logic [DW-1:0]         agt_rd_data;
  logic                  sram_rdy;
  logic                  sram_rd_en;
  logic                  sram_wr_en;
  logic [AW-1:0]         sram_addr;
  logic [DW-1:0]         sram_wr_data;
  logic                  sram_rd_valid;
  logic [DW-1:0]         sram_rd_data;
  logic                  orphan_err;

  typedef struct {
    logic [NA-1:0] vld;
    logic [DW-1:0] data;
  } ret_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   model_tags[$];
  ret_t sb_q[$];
  logic prev_vld = 1'b0;
  bit   mon_en = 1'b0;

  always #5 clk_ir = ~clk_ir;

  syn_sram_acc_arb #(
    .NUM_AGENTS (NA),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .MAX_RD_OUT (MRO)
  ) dut (
    .clk_ir        (clk_ir),
    .rst_il        (rst_il),
    .agt_rd_en     (rd_en_b),
    .agt_wr_en     (wr_en_b),
    .agt_addr      (addr_b),
    .agt_wr_data   (wdata_b),
    .agt_rdy       (agt_rdy),
    .agt_rd_valid  (agt_rd_valid),
    .agt_rd_data   (agt_rd_data),
    .sram_rdy      (sram_rdy),
    .sram_rd_en    (sram_rd_en),
    .sram_wr_en    (sram_wr_en),
    .sram_addr     (sram_addr),
    .sram_wr_data  (sram_wr_data),
    .sram_rd_valid (sram_rd_valid),
    .sram_rd_data  (sram_rd_data),
    .orphan_err    (orphan_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ir);
    @(negedge clk_ir);
  endtask

  // Check the combinational command path for the current inputs; g < 0 means no grant.
  task automatic expect_cmd(input string tag, input int g, input bit e_rd, input bit e_wr, input bit acc);
    logic [NA-1:0] e_rdy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [1:0]    gi;
    #1;
    e_rdy  = '0;
    e_addr = '0;
    e_wd   = '0;
    if (g >= 0) begin
      gi     = g[1:0];
      e_addr = addr_b[gi];
      e_wd   = wdata_b[gi];
      if (acc) e_rdy = NA'(1 << g);
    end
    chk({tag, "_rdy"},   32'(agt_rdy),      32'(e_rdy));
    chk({tag, "_rd_en"}, 32'(sram_rd_en),   32'(e_rd));
    chk({tag, "_wr_en"}, 32'(sram_wr_en),   32'(e_wr));
    chk({tag, "_addr"},  32'(sram_addr),    32'(e_addr));
    chk({tag, "_wdata"}, 32'(sram_wr_data), 32'(e_wd));
    if (acc && e_rd) model_tags.push_back(g);
  endtask

  // Drive one SRAM read-return beat and queue the routing the bench expects for it.
  task automatic sram_ret(input logic [DW-1:0] d);
    ret_t r;
    sram_rd_valid = 1'b1;
    sram_rd_data  = d;
    r.data = d;
    r.vld  = '0;
    if (model_tags.size() > 0) begin
      int t;
      t = model_tags.pop_front();
      r.vld = NA'(1 << t);
    end
    sb_q.push_back(r);
  endtask

  // Remember whether a return beat was presented at this edge.
  always @(posedge clk_ir) prev_vld = sram_rd_valid;

  // Compare routed read returns one cycle after each beat; otherwise no valid may appear.
  always @(negedge clk_ir) begin
    ret_t r;
    if (mon_en) begin
      if (prev_vld) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          r = sb_q.pop_front();
          chk("ret_vld",  32'(agt_rd_valid), 32'(r.vld));
          chk("ret_data", 32'(agt_rd_data),  32'(r.data));
        end
      end else begin
        chk("idle_vld", 32'(agt_rd_valid), 32'd0);
      end
    end
  end

  initial begin
    int cnt[NA];
    rst_il        = 1'b0;
    rd_en_b       = '0;
    wr_en_b       = '0;
    addr_b        = '0;
    wdata_b       = '0;
    sram_rdy      = 1'b0;
    sram_rd_valid = 1'b0;
    sram_rd_data  = '0;
    for (int a = 0; a < NA; a++) cnt[a] = 0;

    // Reset state
    repeat (2) @(negedge clk_ir);
    #1;
    chk("rst_rd_valid", 32'(agt_rd_valid), 32'd0);
    chk("rst_rd_data",  32'(agt_rd_data),  32'd0);
    chk("rst_orphan",   32'(orphan_err),   32'd0);
    chk("rst_rdy",      32'(agt_rdy),      32'd0);
    chk("rst_sram_rd",  32'(sram_rd_en),   32'd0);
    chk("rst_sram_wr",  32'(sram_wr_en),   32'd0);
    chk("rst_sram_adr", 32'(sram_addr),    32'd0);
    @(negedge clk_ir);
    rst_il = 1'b1;
    mon_en = 1'b1;
    tick();

    // Fairness: all agents write continuously
    sram_rdy = 1'b1;
    wr_en_b  = 4'hF;
    for (int a = 0; a < NA; a++) begin
      addr_b[a]  = AW'(a * 256 + 5);
      wdata_b[a] = DW'(16'hC000 + a);
    end
    for (int i = 0; i < 16; i++) begin
      expect_cmd("fair", i % NA, 1'b0, 1'b1, 1'b1);
      for (int a = 0; a < NA; a++) begin
        if (agt_rdy == NA'(1 << a)) cnt[a]++;
      end
      tick();
    end
    for (int a = 0; a < NA; a++) chk("fair_count", 32'(cnt[a]), 32'd4);
    wr_en_b = '0;

    // Read routing: agent 2 then agent 0
    rd_en_b   = 4'b0100;
    addr_b[2] = 18'h00010;
    expect_cmd("rd2", 2, 1'b1, 1'b0, 1'b1);
    tick();
    rd_en_b   = 4'b0001;
    addr_b[0] = 18'h3FFFF;
    expect_cmd("rd0", 0, 1'b1, 1'b0, 1'b1);
    tick();
    rd_en_b = '0;
    expect_cmd("idle", -1, 1'b0, 1'b0, 1'b0);
    tick();
    sram_ret(16'hBEEF);
    tick();
    sram_ret(16'h1234);
    tick();
    sram_rd_valid = 1'b0;
    tick();
    tick();
    chk("route_no_orphan", 32'(orphan_err), 32'd0);

    // Backpressure: agent 1 write held while sram_rdy is low
    sram_rdy   = 1'b0;
    wr_en_b    = 4'b0010;
    addr_b[1]  = 18'h00155;
    wdata_b[1] = 16'hA5A5;
    repeat (5) begin
      expect_cmd("bp_hold", 1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    sram_rdy = 1'b1;
    expect_cmd("bp_go", 1, 1'b0, 1'b1, 1'b1);
    tick();
    // rr_ptr must now be 2: with agents 1 and 2 requesting, 2 wins only from ptr 2
    wr_en_b = 4'b0110;
    expect_cmd("bp_rr_ptr", 2, 1'b0, 1'b1, 1'b1);
    tick();
    wr_en_b = '0;

    // FIFO full: four outstanding reads, fifth blocked until a pop frees a slot
    for (int k = 0; k < 4; k++) begin
      rd_en_b = '0;
      rd_en_b[k % 2] = 1'b1;
      addr_b[k % 2]  = AW'(256 + k);
      expect_cmd("fill", k % 2, 1'b1, 1'b0, 1'b1);
      tick();
    end
    rd_en_b   = 4'b1000;
    addr_b[3] = 18'h2AAAA;
    repeat (2) begin
      expect_cmd("full_blk", 3, 1'b0, 1'b0, 1'b0);
      tick();
    end
    sram_ret(16'h1111);
    expect_cmd("full_blk_pop", 3, 1'b0, 1'b0, 1'b0);
    tick();
    sram_rd_valid = 1'b0;
    expect_cmd("full_acc", 3, 1'b1, 1'b0, 1'b1);
    tick();
    rd_en_b = '0;
    for (int k = 0; k < 4; k++) begin
      sram_ret(DW'(16'h2000 + k));
      tick();
    end
    sram_rd_valid = 1'b0;
    tick();
    tick();

    // Reset with two reads outstanding; later returns are orphans
    rd_en_b   = 4'b0100;
    addr_b[2] = 18'h00020;
    expect_cmd("pre_rst_rd2", 2, 1'b1, 1'b0, 1'b1);
    tick();
    rd_en_b   = 4'b0010;
    addr_b[1] = 18'h00021;
    expect_cmd("pre_rst_rd1", 1, 1'b1, 1'b0, 1'b1);
    tick();
    rd_en_b = '0;
    rst_il  = 1'b0;
    model_tags.delete();
    #1;
    chk("midrst_orphan",  32'(orphan_err),   32'd0);
    chk("midrst_rd_data", 32'(agt_rd_data),  32'd0);
    tick();
    rst_il = 1'b1;
    tick();
    sram_ret(16'hDEAD);
    tick();
    sram_ret(16'hF00D);
    tick();
    sram_rd_valid = 1'b0;
    #1;
    chk("orphan_set", 32'(orphan_err), 32'd1);
    tick();
    tick();
    tick();
    chk("orphan_sticky", 32'(orphan_err), 32'd1);

    // Agent 3 with read and write both asserted: write only, no tag pushed
    rd_en_b    = 4'b1000;
    wr_en_b    = 4'b1000;
    addr_b[3]  = 18'h0ABCD;
    wdata_b[3] = 16'h5A5A;
    expect_cmd("rw3", 3, 1'b0, 1'b1, 1'b1);
    tick();
    rd_en_b = '0;
    wr_en_b = '0;
    tick();
    sram_ret(16'h7777);
    tick();
    sram_rd_valid = 1'b0;
    tick();
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
